// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues ROM reads, buffers returned words in a
// small FIFO and hands them to decode over valid/ready, with branch redirect.
module fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  discard;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];

  logic          valid;
  logic          pop;
  logic          wr;
  logic [CW:0]   need;

  assign valid = ~reset & (count != '0);
  assign pop   = valid & instr_ready;
  assign wr    = inflight & ~discard & ~redirect & ~reset;

  // Occupancy once this cycle settles, counting the fetch still in flight.
  assign need = {1'b0, count}
              + (CW+1)'(inflight)
              - (CW+1)'(pop);

  assign rom_en = ~reset & ~redirect
                & (need < (CW+1)'(FIFO_DEPTH));
  assign rom_addr = fetch_pc;

  assign instr_valid = valid;
  assign instr_out   = valid ? mem_data[rptr] : '0;
  assign instr_pc    = valid ? mem_pc[rptr]   : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      discard     <= 1'b0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      discard  <= inflight;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      inflight <= rom_en;
      discard  <= 1'b0;
      if (rom_en) begin
        fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
        inflight_pc <= fetch_pc;
      end
      if (wr) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      unique case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr) begin
      mem_data[wptr] <= rom_data;
      mem_pc[wptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run scored against an expected-PC stream model.
module tb_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [7:0]  instr_pc;

  logic        w_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [7:0]  w_rpc = 8'h00;
  logic        w_rom_en;
  logic [7:0]  w_rom_addr;
  logic [31:0] w_rom_data;
  logic        w_valid;
  logic [31:0] w_out;
  logic [7:0]  w_pc;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_pc = 8'h00;

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(8'hFE)) dut_w (
    .clock(clock), .reset(reset),
    .rom_en(w_rom_en), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr_out(w_out), .instr_pc(w_pc),
    .redirect(w_redirect), .redirect_pc(w_rpc)
  );

  function automatic logic [31:0] romf(input logic [7:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  always @(posedge clock) begin
    rom_data   <= rom_en ? romf(rom_addr) : 32'hDEAD_BEEF;
    w_rom_data <= w_rom_en ? romf(w_rom_addr) : 32'hDEAD_BEEF;
  end

  task automatic drive(input logic rst, input logic rdy,
                       input logic rd, input logic [7:0] rpc);
    reset = rst;
    instr_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    @(negedge clock);
  endtask

  task automatic step();
    if (reset) exp_pc = 8'h00;
    else if (redirect) exp_pc = redirect_pc;
    else if (instr_valid && instr_ready) exp_pc = exp_pc + 8'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    step();
    drive(1, 0, 0, 0);
    total++;
    if (rom_en !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: en=%b valid=%b want 0 0", rom_en, instr_valid);
    end
    total++;
    if (instr_out !== 32'h0 || instr_pc !== 8'h0) begin
      bad++;
      $display("FAIL reset_out: out=%h pc=%h want 0 0", instr_out, instr_pc);
    end
    total++;
    if (rom_addr !== 8'h00 || w_rom_addr !== 8'hFE) begin
      bad++;
      $display("FAIL reset_addr: %h %h want 00 fe", rom_addr, w_rom_addr);
    end
    step();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0);
      total++;
      if (rom_en !== 1'b1 || rom_addr !== 8'(k)) begin
        bad++;
        $display("FAIL seq_issue: en=%b addr=%h want 1 %h", rom_en, rom_addr, 8'(k));
      end
      total++;
      if (instr_valid !== (k >= 2)) begin
        bad++;
        $display("FAIL seq_valid: cyc %0d got %b want %b", k, instr_valid, (k >= 2));
      end
      if (k >= 2) begin
        total++;
        if (instr_pc !== 8'(k - 2) || instr_out !== romf(8'(k - 2))) begin
          bad++;
          $display("FAIL seq_data: pc=%h out=%h want %h %h", instr_pc, instr_out,
                   8'(k - 2), romf(8'(k - 2)));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    held = exp_pc;
    for (int j = 0; j < 6; j++) begin
      drive(0, 0, 0, 0);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== held || instr_out !== romf(held)) begin
        bad++;
        $display("FAIL bp_hold: v=%b pc=%h out=%h want 1 %h", instr_valid, instr_pc,
                 instr_out, held);
      end
      if (j >= 2) begin
        total++;
        if (rom_en !== 1'b0) begin
          bad++;
          $display("FAIL bp_stall: rom_en=%b want 0", rom_en);
        end
      end
      step();
    end
    for (int r = 0; r < 6; r++) begin
      drive(0, 1, 0, 0);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== romf(exp_pc)) begin
        bad++;
        $display("FAIL bp_resume: v=%b pc=%h want 1 %h", instr_valid, instr_pc, exp_pc);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    drive(0, 1, 1, 8'h40);
    total++;
    if (instr_valid !== 1'b1 || rom_en !== 1'b0) begin
      bad++;
      $display("FAIL rd_cycle: v=%b en=%b want 1 0", instr_valid, rom_en);
    end
    step();
    drive(0, 1, 0, 0);
    total++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h40 || rom_en !== 1'b1) begin
      bad++;
      $display("FAIL rd_next: v=%b addr=%h en=%b want 0 40 1", instr_valid, rom_addr, rom_en);
    end
    step();
    drive(0, 1, 0, 0);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_lat2: v=%b want 0", instr_valid);
    end
    step();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 0);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'(8'h40 + c) || instr_out !== romf(8'(8'h40 + c))) begin
        bad++;
        $display("FAIL rd_stream: v=%b pc=%h want 1 %h", instr_valid, instr_pc, 8'(8'h40 + c));
      end
      step();
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0);
      step();
    end
    drive(0, 0, 1, 8'h60);
    step();
    drive(0, 1, 0, 0);
    total++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h60) begin
      bad++;
      $display("FAIL rd_full: v=%b addr=%h want 0 60", instr_valid, rom_addr);
    end
    step();
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 0);
      if (instr_valid) begin
        total++;
        if (instr_pc !== exp_pc || instr_out !== romf(exp_pc)) begin
          bad++;
          $display("FAIL rd_full_stream: pc=%h want %h", instr_pc, exp_pc);
        end
      end
      step();
    end
    total++;
    if (exp_pc !== 8'h63) begin
      bad++;
      $display("FAIL rd_full_count: next pc %h want 63", exp_pc);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 1, 8'h80);
    step();
    drive(0, 1, 1, 8'h90);
    total++;
    if (instr_valid !== 1'b0 || rom_en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_mid: v=%b en=%b want 0 0", instr_valid, rom_en);
    end
    step();
    drive(0, 1, 0, 0);
    total++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h90) begin
      bad++;
      $display("FAIL b2b_addr: v=%b addr=%h want 0 90", instr_valid, rom_addr);
    end
    step();
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 0, 0);
      if (instr_valid) begin
        total++;
        if (instr_pc !== exp_pc || instr_out !== romf(exp_pc)) begin
          bad++;
          $display("FAIL b2b_stream: pc=%h want %h", instr_pc, exp_pc);
        end
      end
      step();
    end
    total++;
    if (exp_pc !== 8'h94) begin
      bad++;
      $display("FAIL b2b_count: next pc %h want 94", exp_pc);
    end
  endtask

  task automatic test_wrap();
    drive(1, 1, 0, 0);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 0);
      if (k >= 2) begin
        total++;
        if (w_valid !== 1'b1 || w_pc !== 8'(8'hFE + k - 2) || w_out !== romf(8'(8'hFE + k - 2))) begin
          bad++;
          $display("FAIL wrap: v=%b pc=%h want 1 %h", w_valid, w_pc, 8'(8'hFE + k - 2));
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 0);
      step();
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 0);
    total++;
    if (instr_valid !== 1'b0 || instr_out !== 32'h0 || rom_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: v=%b out=%h en=%b want 0 0 0", instr_valid, instr_out, rom_en);
    end
    step();
    drive(0, 1, 0, 0);
    total++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_next: v=%b addr=%h want 0 00", instr_valid, rom_addr);
    end
    step();
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 0, 0);
      if (instr_valid) begin
        total++;
        if (instr_pc !== exp_pc || instr_out !== romf(exp_pc)) begin
          bad++;
          $display("FAIL rst_mid_stream: pc=%h want %h", instr_pc, exp_pc);
        end
      end
      step();
    end
    total++;
    if (exp_pc !== 8'h04) begin
      bad++;
      $display("FAIL rst_mid_count: next pc %h want 04", exp_pc);
    end
  endtask

  task automatic test_random();
    int gap;
    logic rst, rd, rdy;
    logic [7:0] rpc;
    gap = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      rd = !rst && ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = 8'($urandom);
      drive(rst, rdy, rd, rpc);
      total++;
      if (instr_valid) begin
        if (instr_pc !== exp_pc || instr_out !== romf(exp_pc)) begin
          bad++;
          $display("FAIL rand_head: pc=%h out=%h want %h %h", instr_pc, instr_out,
                   exp_pc, romf(exp_pc));
        end
      end else if (instr_pc !== 8'h0 || instr_out !== 32'h0) begin
        bad++;
        $display("FAIL rand_idle: pc=%h out=%h want 0 0", instr_pc, instr_out);
      end
      if (rst || rd) begin
        total++;
        if (rom_en !== 1'b0) begin
          bad++;
          $display("FAIL rand_noissue: rom_en=%b want 0", rom_en);
        end
        gap = 0;
      end else if (instr_valid) begin
        gap = 0;
      end else begin
        gap++;
        total++;
        if (gap > 2) begin
          bad++;
          $display("FAIL rand_gap: %0d empty cycles, max 2", gap);
        end
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
